hq2x_line_writer: RTL and testbench
===================================

# hq2x_line_writer

Upstream capture stage for the hq2x double-buffered input line store. Takes the pixel-rate video stream (pixel enable, blanking, pixel word) and produces the write side of the line store: write address, write buffer select, data and write enable. At each line end it flips the write buffer and reports the completed line length, so the downstream reader can consume the finished line from the other buffer.

## Interface
- LENGTH, 0: max pixels per line stored; must match the line store's LENGTH.
- DWIDTH, 0: pixel MSB index; the pixel word is DWIDTH+1 bits.
- AWIDTH (localparam): 0 if LENGTH<=2, 1 if <=4, … 9 if <=1024, else 10; the address is AWIDTH+1 bits.

- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- ce_pix  in  1  pixel enable; inputs are sampled only when high.
- hblank  in  1  horizontal blank.
- vblank  in  1  vertical blank.
- pixel  in  DWIDTH+1  input pixel word.
- wraddr  out  AWIDTH+1  line store write address.
- wrbuf  out  1  line store buffer being written.
- data  out  DWIDTH+1  line store write data.
- wren  out  1  line store write enable.
- line_done  out  1  one-clk pulse: a line completed; the buffer is now readable.
- line_len  out  AWIDTH+2  pixel count of the last completed line.
- frame_start  out  1  one-clk pulse on vblank falling edge.
- ovf  out  1  current line exceeded LENGTH; cleared at the next line start.

## Operation
- Internal column counter col is AWIDTH+2 bits. hblank_d and vblank_d hold the previous sampled values. All of these update only on ce_pix.
- Active pixel (ce_pix & ~hblank & ~vblank):
  - if col < LENGTH: write pixel at address col, then col++.
  - else: drop the pixel, do not pulse wren, and set ovf.
- Line end (ce_pix & hblank & ~hblank_d & ~vblank):
  - if col > 0: toggle wrbuf, line_len <= col, pulse line_done, col <= 0, ovf <= 0.
  - if col == 0 (empty line): no toggle and no pulse.
- vblank rising (ce_pix & vblank & ~vblank_d): discard any partial line (col <= 0, ovf <= 0). No toggle, no line_done.
- vblank falling (ce_pix & ~vblank & vblank_d): pulse frame_start. wrbuf is not changed, so its parity runs free across frames.
- Simultaneous hblank and vblank rising on the same sample: vblank wins, and the line is discarded.
- ce_pix low: no state changes, and wren, line_done and frame_start are 0.

## Timing
- Reset values:
  - wraddr=0, wrbuf=0, data=0, wren=0, line_done=0, line_len=0, frame_start=0, ovf=0.
  - col=0, hblank_d=1, vblank_d=1, so the first samples after reset produce no spurious edges.
- Base latency is 1 clk: the wren/wraddr/data for a sampled pixel are registered and appear the clk after the ce_pix sample.
- wren is a single-clk pulse per accepted pixel.
- line_done and the new wrbuf and line_len take effect on the same clk, 1 clk after the hblank-rise sample.
  - The final pixel's write (issued at the earlier sample) therefore always lands in the old buffer before the flip.
- Back-to-back ce_pix every clk is supported at full rate.
- Reset asserted mid-line: all state is cleared next clk, and the partial line is lost without a line_done.

## Configuration
- HQ2X_LINEW_REG_EN defined:
  - Adds a second output register on wraddr, data and wren (latency 2 clk).
  - line_done, wrbuf and line_len are delayed by the same extra clk, so ordering relative to the last write is preserved.
  - Use this for timing closure into block RAM.
- Undefined: latency 1 clk as described above.

## Test plan
- Reset, then LENGTH=8, ce_pix every clk, 5 active pixels 0x1..0x5, then hblank rising. Required:
  - wren pulses at addresses 0..4 with data 1..5, all on wrbuf=0.
  - Then a line_done pulse, wrbuf=1, line_len=5.
- LENGTH=8, 11 active pixels. Required:
  - 8 writes at addresses 0..7.
  - ovf=1 from the 9th pixel onward.
  - At line end: line_len=8, and ovf returns to 0.
- hblank rising with col=0, and again during vblank. Required: no line_done, wrbuf unchanged.
- 3 pixels, then vblank and hblank rise on the same sample. Required:
  - No line_done, wrbuf unchanged, col reset.
  - frame_start pulses exactly once when vblank falls.
- ce_pix every 4th clk, 2 lines of 4 pixels. Required:
  - Writes occur only 1 clk after ce samples.
  - wrbuf reads 0, then 1, then 0 at the two line ends.
- Reset asserted after 2 pixels of a line. Required: all outputs 0 next clk, and no line_done follows the next hblank rise.

Source files
------------

// File: rtl/hq2x_line_writer.sv
// hq2x line writer: turns the pixel-rate video stream into double-buffered line store writes.
// Define HQ2X_LINEW_REG_EN to add a second output register stage (latency 2) for block RAM timing.
module hq2x_line_writer #(
    parameter int LENGTH = 0,
    parameter int DWIDTH = 0,
    localparam int AWIDTH = (LENGTH <= 2)   ? 0 :
                            (LENGTH <= 4)   ? 1 :
                            (LENGTH <= 8)   ? 2 :
                            (LENGTH <= 16)  ? 3 :
                            (LENGTH <= 32)  ? 4 :
                            (LENGTH <= 64)  ? 5 :
                            (LENGTH <= 128) ? 6 :
                            (LENGTH <= 256) ? 7 :
                            (LENGTH <= 512) ? 8 :
                            (LENGTH <= 1024) ? 9 : 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce_pix,
    input  logic              hblank,
    input  logic              vblank,
    input  logic [DWIDTH:0]   pixel,
    output logic [AWIDTH:0]   wraddr,
    output logic              wrbuf,
    output logic [DWIDTH:0]   data,
    output logic              wren,
    output logic              line_done,
    output logic [AWIDTH+1:0] line_len,
    output logic              frame_start,
    output logic              ovf
);

    localparam logic [AWIDTH+1:0] LEN_C = (AWIDTH+2)'(LENGTH);

    logic [AWIDTH+1:0] col_q, col_d;
    logic              hblankPrev_q, hblankPrev_d;
    logic              vblankPrev_q, vblankPrev_d;
    logic [AWIDTH:0]   wraddr_q, wraddr_d;
    logic [DWIDTH:0]   data_q, data_d;
    logic              wren_q, wren_d;
    logic              wrbuf_q, wrbuf_d;
    logic              lineDone_q, lineDone_d;
    logic [AWIDTH+1:0] lineLen_q, lineLen_d;
    logic              frameStart_q, frameStart_d;
    logic              ovf_q, ovf_d;

    // A vblank rise takes priority over a coincident hblank rise and discards the partial line.
    always_comb begin
        col_d        = col_q;
        hblankPrev_d = hblankPrev_q;
        vblankPrev_d = vblankPrev_q;
        wraddr_d     = wraddr_q;
        data_d       = data_q;
        wren_d       = 1'b0;
        wrbuf_d      = wrbuf_q;
        lineDone_d   = 1'b0;
        lineLen_d    = lineLen_q;
        frameStart_d = 1'b0;
        ovf_d        = ovf_q;
        if (ce_pix) begin
            hblankPrev_d = hblank;
            vblankPrev_d = vblank;
            if (!hblank && !vblank) begin
                if (col_q < LEN_C) begin
                    wren_d   = 1'b1;
                    wraddr_d = col_q[AWIDTH:0];
                    data_d   = pixel;
                    col_d    = col_q + 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
            end
            if (vblank && !vblankPrev_q) begin
                col_d = '0;
                ovf_d = 1'b0;
            end else if (hblank && !hblankPrev_q && !vblank && (col_q != '0)) begin
                wrbuf_d    = ~wrbuf_q;
                lineLen_d  = col_q;
                lineDone_d = 1'b1;
                col_d      = '0;
                ovf_d      = 1'b0;
            end
            if (!vblank && vblankPrev_q) begin
                frameStart_d = 1'b1;
            end
        end
    end

    // Blanking history resets high so the first samples after reset see no edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_q        <= '0;
            hblankPrev_q <= 1'b1;
            vblankPrev_q <= 1'b1;
            wraddr_q     <= '0;
            data_q       <= '0;
            wren_q       <= 1'b0;
            wrbuf_q      <= 1'b0;
            lineDone_q   <= 1'b0;
            lineLen_q    <= '0;
            frameStart_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            col_q        <= col_d;
            hblankPrev_q <= hblankPrev_d;
            vblankPrev_q <= vblankPrev_d;
            wraddr_q     <= wraddr_d;
            data_q       <= data_d;
            wren_q       <= wren_d;
            wrbuf_q      <= wrbuf_d;
            lineDone_q   <= lineDone_d;
            lineLen_q    <= lineLen_d;
            frameStart_q <= frameStart_d;
            ovf_q        <= ovf_d;
        end
    end

    assign frame_start = frameStart_q;
    assign ovf         = ovf_q;

`ifdef HQ2X_LINEW_REG_EN
    logic [AWIDTH:0]   wraddrOut_q;
    logic [DWIDTH:0]   dataOut_q;
    logic              wrenOut_q;
    logic              wrbufOut_q;
    logic              lineDoneOut_q;
    logic [AWIDTH+1:0] lineLenOut_q;

    // Write path and buffer flip are delayed together so the last write still precedes the flip.
    always_ff @(posedge clk) begin
        if (reset) begin
            wraddrOut_q   <= '0;
            dataOut_q     <= '0;
            wrenOut_q     <= 1'b0;
            wrbufOut_q    <= 1'b0;
            lineDoneOut_q <= 1'b0;
            lineLenOut_q  <= '0;
        end else begin
            wraddrOut_q   <= wraddr_q;
            dataOut_q     <= data_q;
            wrenOut_q     <= wren_q;
            wrbufOut_q    <= wrbuf_q;
            lineDoneOut_q <= lineDone_q;
            lineLenOut_q  <= lineLen_q;
        end
    end

    assign wraddr    = wraddrOut_q;
    assign data      = dataOut_q;
    assign wren      = wrenOut_q;
    assign wrbuf     = wrbufOut_q;
    assign line_done = lineDoneOut_q;
    assign line_len  = lineLenOut_q;
`else
    assign wraddr    = wraddr_q;
    assign data      = data_q;
    assign wren      = wren_q;
    assign wrbuf     = wrbuf_q;
    assign line_done = lineDone_q;
    assign line_len  = lineLen_q;
`endif

endmodule

// File: tb/tb_hq2x_line_writer.sv
// Directed bench for hq2x_line_writer (LENGTH=8, 8-bit pixels) with a write/line-end scoreboard.
module tb_hq2x_line_writer;

    localparam int LENGTH = 8;
    localparam int DWIDTH = 7;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ce_pix = 1'b0;
    logic       hblank = 1'b1;
    logic       vblank = 1'b1;
    logic [7:0] pixel = 8'h00;
    logic [2:0] wraddr;
    logic       wrbuf;
    logic [7:0] data;
    logic       wren;
    logic       line_done;
    logic [3:0] line_len;
    logic       frame_start;
    logic       ovf;

    hq2x_line_writer #(.LENGTH(LENGTH), .DWIDTH(DWIDTH)) dut (
        .clk(clk),
        .reset(reset),
        .ce_pix(ce_pix),
        .hblank(hblank),
        .vblank(vblank),
        .pixel(pixel),
        .wraddr(wraddr),
        .wrbuf(wrbuf),
        .data(data),
        .wren(wren),
        .line_done(line_done),
        .line_len(line_len),
        .frame_start(frame_start),
        .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] addr;
        logic [7:0] pix;
        logic       wbuf;
        int         cyc;
    } wr_t;

    typedef struct {
        logic [3:0] len;
        logic       wbuf;
        int         cyc;
    } done_t;

    wr_t   wrQ[$];
    done_t doneQ[$];
    wr_t   wrE;
    done_t doneE;

    int checks = 0;
    int fails = 0;
    int cycle = 0;
    int frameSeen = 0;
    int expFrames = 0;

    int   mCol;
    logic mBuf;
    logic mHbPrev;
    logic mVbPrev;

    always @(posedge clk) cycle++;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every write and line end the DUT produces is matched in order.
    always @(negedge clk) begin
        if (wren === 1'b1) begin
            checkOutput("wr_expected", 32'(wrQ.size() > 0), 32'd1);
            if (wrQ.size() > 0) begin
                wrE = wrQ.pop_front();
                checkOutput("wr_addr", 32'(wraddr), 32'(wrE.addr));
                checkOutput("wr_data", 32'(data), 32'(wrE.pix));
                checkOutput("wr_buf", 32'(wrbuf), 32'(wrE.wbuf));
                checkOutput("wr_cycle", cycle, wrE.cyc);
            end
        end
        if (line_done === 1'b1) begin
            checkOutput("done_expected", 32'(doneQ.size() > 0), 32'd1);
            if (doneQ.size() > 0) begin
                doneE = doneQ.pop_front();
                checkOutput("done_len", 32'(line_len), 32'(doneE.len));
                checkOutput("done_buf", 32'(wrbuf), 32'(doneE.wbuf));
                checkOutput("done_cycle", cycle, doneE.cyc);
            end
        end
        if (frame_start === 1'b1) frameSeen++;
    end

    // Drive one sample, advance the reference model, and return just after the sampling edge.
    task automatic applyStimulus(input logic ce, input logic hb, input logic vb, input logic [7:0] pix);
        ce_pix = ce;
        hblank = hb;
        vblank = vb;
        pixel  = pix;
        if (ce) begin
            if (!hb && !vb && mCol < LENGTH) begin
                wrQ.push_back('{addr: 3'(mCol), pix: pix, wbuf: mBuf, cyc: cycle + 1});
                mCol++;
            end
            if (vb && !mVbPrev) begin
                mCol = 0;
            end else if (hb && !mHbPrev && !vb && mCol > 0) begin
                mBuf = ~mBuf;
                doneQ.push_back('{len: 4'(mCol), wbuf: mBuf, cyc: cycle + 1});
                mCol = 0;
            end
            if (!vb && mVbPrev) expFrames++;
            mHbPrev = hb;
            mVbPrev = vb;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, hblank, vblank, pixel);
            checkOutput("idle_wren", 32'(wren), 32'd0);
        end
    endtask

    task automatic doReset(input int n);
        reset  = 1'b1;
        ce_pix = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("rst_wraddr", 32'(wraddr), 32'd0);
        checkOutput("rst_wrbuf", 32'(wrbuf), 32'd0);
        checkOutput("rst_data", 32'(data), 32'd0);
        checkOutput("rst_wren", 32'(wren), 32'd0);
        checkOutput("rst_line_done", 32'(line_done), 32'd0);
        checkOutput("rst_line_len", 32'(line_len), 32'd0);
        checkOutput("rst_frame_start", 32'(frame_start), 32'd0);
        checkOutput("rst_ovf", 32'(ovf), 32'd0);
        reset   = 1'b0;
        mCol    = 0;
        mBuf    = 1'b0;
        mHbPrev = 1'b1;
        mVbPrev = 1'b1;
    endtask

    initial begin
        $display("[TB] start");
        doReset(3);

        // Basic line of 5 pixels; the first active sample is also the vblank fall.
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 8'(i));
            if (i == 1) checkOutput("fs_first_line", 32'(frame_start), 32'd1);
            if (i == 2) checkOutput("fs_one_clk", 32'(frame_start), 32'd0);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput("l1_done", 32'(line_done), 32'd1);
        checkOutput("l1_wrbuf", 32'(wrbuf), 32'd1);
        checkOutput("l1_len", 32'(line_len), 32'd5);
        checkOutput("l1_wren_at_flip", 32'(wren), 32'd0);

        // Overflowing line of 11 pixels.
        for (int i = 1; i <= 11; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 8'(8'h10 + i));
            if (i == 8) checkOutput("ovf_at_8", 32'(ovf), 32'd0);
            if (i >= 9) checkOutput("ovf_after_8", 32'(ovf), 32'd1);
            if (i >= 9) checkOutput("ovf_no_wren", 32'(wren), 32'd0);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput("ovf_done", 32'(line_done), 32'd1);
        checkOutput("ovf_len", 32'(line_len), 32'd8);
        checkOutput("ovf_wrbuf", 32'(wrbuf), 32'd0);
        checkOutput("ovf_cleared", 32'(ovf), 32'd0);

        // Empty lines: hblank rise during vblank, then with col=0 as vblank falls.
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h00);
        checkOutput("vb_hrise_done", 32'(line_done), 32'd0);
        checkOutput("vb_hrise_wrbuf", 32'(wrbuf), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput("empty_done", 32'(line_done), 32'd0);
        checkOutput("empty_wrbuf", 32'(wrbuf), 32'd0);
        checkOutput("empty_fs", 32'(frame_start), 32'd1);

        // Partial line killed by simultaneous hblank/vblank rise.
        for (int i = 1; i <= 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'(8'h20 + i));
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h00);
        checkOutput("both_done", 32'(line_done), 32'd0);
        checkOutput("both_wrbuf", 32'(wrbuf), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h00);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput("both_fs", 32'(frame_start), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput("both_fs_once", 32'(frame_start), 32'd0);

        // Sparse ce_pix: two lines of 4 pixels, one sample every 4th clk.
        checkOutput("sparse_wrbuf0", 32'(wrbuf), 32'd0);
        for (int ln = 0; ln < 2; ln++) begin
            for (int i = 1; i <= 4; i++) begin
                applyStimulus(1'b1, 1'b0, 1'b0, 8'(8'h30 + 8 * ln + i));
                checkOutput("sparse_wren", 32'(wren), 32'd1);
                idle(3);
            end
            applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
            checkOutput("sparse_done", 32'(line_done), 32'd1);
            checkOutput("sparse_len", 32'(line_len), 32'd4);
            checkOutput("sparse_wrbuf", 32'(wrbuf), (ln == 0) ? 32'd1 : 32'd0);
            idle(3);
            checkOutput("sparse_done_pulse", 32'(line_done), 32'd0);
        end

        // Reset after 2 pixels of a line.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h51);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h52);
        doReset(1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
            checkOutput("post_rst_done", 32'(line_done), 32'd0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h61);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h62);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput("post_rst_len", 32'(line_len), 32'd2);
        checkOutput("post_rst_wrbuf", 32'(wrbuf), 32'd1);

        idle(4);
        checkOutput("wr_queue_drained", wrQ.size(), 0);
        checkOutput("done_queue_drained", doneQ.size(), 0);
        checkOutput("frame_start_count", frameSeen, expFrames);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
